vga_timing_generator: RTL and testbench
=======================================

VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 Parameter CLK_DIV, default 4: clk_in cycles per pixel (100 MHz in, 25 MHz pixel rate).
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal phase lengths in pixels.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical phase lengths in lines.
REQ-004 clk_in  input  1  the only clock; all logic on posedge.
REQ-005 rst_n_in  input  1  synchronous, active-low reset.
REQ-006 current_row  output  10  horizontal pixel coordinate (x), 0..H_ACTIVE-1.
REQ-007 current_line  output  10  vertical pixel coordinate (y), 0..V_ACTIVE-1.
REQ-008 enable  output  1  high only inside the visible area.
REQ-009 hsync  output  1  horizontal sync, active low.
REQ-010 vsync  output  1  vertical sync, active low.
REQ-011 pixel_tick  output  1  one-cycle strobe marking each pixel slot.
REQ-012 frame_start  output  1  one-cycle pulse when pixel (0,0) is presented.

Function
REQ-013 The divider counts 0..CLK_DIV-1 and wraps; pixel_tick is high (combinationally) only when divider = CLK_DIV-1; CLK_DIV=1 gives a tick every cycle.
REQ-014 h_cnt counts 0..HT-1 (HT = sum of H phases = 800) and advances only on pixel_tick; 799 wraps to 0 and advances v_cnt.
REQ-015 v_cnt counts 0..VT-1 (VT = 525); 524 wraps to 0 on the same tick as the h_cnt wrap.
REQ-016 Each axis runs a phase FSM, ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, with each transition at its phase boundary; the vertical FSM steps only on the horizontal wrap.
REQ-017 Outputs are registered and load, on the pixel_tick cycle, the decode of the pre-advance counters; latency is one clk_in from tick to outputs, and outputs hold between ticks.
REQ-018 Decode for enable: h_cnt<640 and v_cnt<480.
REQ-019 Decode for current_row and current_line: equal to h_cnt and v_cnt while in the active area of their own axis, else 0.
REQ-020 Decode for hsync: low for 656<=h_cnt<752; vsync: low for 490<=v_cnt<492; both high elsewhere.
REQ-021 frame_start is high for exactly one clk_in cycle, the cycle in which outputs first show h_cnt=0, v_cnt=0.
REQ-022 Counter widths are 10 bits; no counter exceeds its terminal value for any legal parameter set.

Reset
REQ-023 While rst_n_in=0 at a clock edge: divider, h_cnt and v_cnt are 0, FSMs are ACTIVE, current_row=0, current_line=0, enable=0, hsync=1, vsync=1, frame_start=0.
REQ-024 Reset asserted mid-frame is taken at the next edge with no partial-line completion; after release, the first tick occurs CLK_DIV cycles later and presents pixel (0,0) with frame_start=1.

Configuration
REQ-025 With VGA_FRAME_COUNTER_EN defined, there is an extra output frame_count (8 bits) that resets to 0, increments on each frame_start and wraps 255->0.
REQ-026 Without VGA_FRAME_COUNTER_EN, the frame_count port and logic are absent and all other behaviour is identical.

Structure
REQ-027 Shared package/include vga_timing_pkg holds default timing constants, HT/VT, sync start/end values and the phase-state encoding (ACTIVE/FRONT/SYNC/BACK).
REQ-028 One sub-module, vga_axis_counter, contains counter, phase FSM and decode for one axis, instantiated twice (horizontal stepped by pixel_tick, vertical by horizontal wrap).

Verification
REQ-029 Release reset, count cycles: pixel_tick at cycles 4, 8, 12...; first output (row 0, line 0, enable=1, frame_start=1) one cycle after first tick.
REQ-030 One full line: enable high 640 ticks, hsync low exactly 96 ticks starting tick 656, line period 800 ticks = 3200 clk_in.
REQ-031 One full frame: vsync low for 2 lines (490-491), enable never high for line>=480, frame_start period 420000 ticks.
REQ-032 Reset pulse at h=700, v=300 -> next edge all outputs at reset values, restart at (0,0).
REQ-033 CLK_DIV=1 build: tick every cycle, line = 800 clk_in; with VGA_FRAME_COUNTER_EN, frame_count goes 255 -> 0 after 256 frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, totals, sync window bounds and phase encoding.
package vga_timing_pkg;
    localparam int CNT_W        = 10;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int HT           = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int VT           = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis -- position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_active,
    output logic             o_sync
);
    localparam logic [CNT_W-1:0] L_ACT_END  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] L_FP_END   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] L_SYNC_END = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] L_LAST     = CNT_W'(ACTIVE + FP + SYNC + BP - 1);

    logic [CNT_W-1:0] r_cnt;
    phase_t           r_state;
    phase_t           w_next;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_state <= PH_ACTIVE;
        end else begin
            r_state <= w_next;
            if (i_step)
                r_cnt <= (r_cnt == L_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Phase boundaries line up with the counter so the FSM never drifts from r_cnt.
    always_comb begin
        w_next = r_state;
        if (i_step) begin
            case (r_state)
                PH_ACTIVE: w_next = (r_cnt == L_ACT_END)  ? PH_FRONT  : PH_ACTIVE;
                PH_FRONT:  w_next = (r_cnt == L_FP_END)   ? PH_SYNC   : PH_FRONT;
                PH_SYNC:   w_next = (r_cnt == L_SYNC_END) ? PH_BACK   : PH_SYNC;
                PH_BACK:   w_next = (r_cnt == L_LAST)     ? PH_ACTIVE : PH_BACK;
                default:   w_next = PH_ACTIVE;
            endcase
        end
    end

    assign o_cnt    = r_cnt;
    assign o_active = (r_state == PH_ACTIVE);
    assign o_sync   = (r_state == PH_SYNC);
endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: VGA sync/coordinate timing with registered outputs.
// Optional 8-bit frame_count output when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    output logic [CNT_W-1:0] current_row,
    output logic [CNT_W-1:0] current_line,
    output logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             pixel_tick,
    output logic             frame_start
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [7:0]       frame_count
`endif
);
    localparam int               DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]    L_DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] L_H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    logic [DW-1:0]    r_div;
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_active;
    logic             w_v_active;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_v_step;
    logic             w_origin;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_line;
    logic             r_enable;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;

    assign pixel_tick = (r_div == L_DIV_LAST);
    assign w_v_step   = pixel_tick && (w_h_cnt == L_H_LAST);
    assign w_origin   = (w_h_cnt == '0) && (w_v_cnt == '0);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in)
            r_div <= '0;
        else
            r_div <= pixel_tick ? '0 : r_div + DW'(1);
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .i_clk    (clk_in),
        .i_rst_n  (rst_n_in),
        .i_step   (pixel_tick),
        .o_cnt    (w_h_cnt),
        .o_active (w_h_active),
        .o_sync   (w_h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .i_clk    (clk_in),
        .i_rst_n  (rst_n_in),
        .i_step   (w_v_step),
        .o_cnt    (w_v_cnt),
        .o_active (w_v_active),
        .o_sync   (w_v_sync)
    );

    // Outputs capture the decode of the counters as they stand on the tick, before they advance.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_row         <= '0;
            r_line        <= '0;
            r_enable      <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pixel_tick && w_origin;
            if (pixel_tick) begin
                r_row    <= w_h_active ? w_h_cnt : '0;
                r_line   <= w_v_active ? w_v_cnt : '0;
                r_enable <= w_h_active && w_v_active;
                r_hsync  <= !w_h_sync;
                r_vsync  <= !w_v_sync;
            end
        end
    end

    assign current_row  = r_row;
    assign current_line = r_line;
    assign enable       = r_enable;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign frame_start  = r_frame_start;

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in)
            r_frame_count <= '0;
        else if (pixel_tick && w_origin)
            r_frame_count <= r_frame_count + 8'd1;
    end

    assign frame_count = r_frame_count;
`endif
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: directed checks on a default-timing DUT and a tiny CLK_DIV=1 DUT.
// Small DUT: H 8/2/3/3 (HT=16, hsync low h 10..12), V 4/1/2/1 (VT=8, vsync low v 5..6).
module tb_vga_timing_generator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_rst_n = 1'b0;
    logic [9:0] row, line, s_row, s_line;
    logic       en, hs, vs, tick, fs;
    logic       s_en, s_hs, s_vs, s_tick, s_fs;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fc, s_fc;
`endif
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_generator u_dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .current_row  (row),
        .current_line (line),
        .enable       (en),
        .hsync        (hs),
        .vsync        (vs),
        .pixel_tick   (tick),
        .frame_start  (fs)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_count  (fc)
`endif
    );

    vga_timing_generator #(
        .CLK_DIV  (1),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) u_small (
        .clk_in       (clk),
        .rst_n_in     (s_rst_n),
        .current_row  (s_row),
        .current_line (s_line),
        .enable       (s_en),
        .hsync        (s_hs),
        .vsync        (s_vs),
        .pixel_tick   (s_tick),
        .frame_start  (s_fs)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_count  (s_fc)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 16; i++) begin
            if (tick) return;
            @(negedge clk);
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic big_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int en_n, hs_lo, hs_first, bad, c0, c1;
        int h, v, b_row, b_line, b_en, b_hs, b_vs, b_fs, b_tick;
        int fs_n, fs_last, fs_gap, vs_lo, s_en_n;
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row", row, 0);
        chk("rst_line", line, 0);
        chk("rst_en", en, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_fs", fs, 0);
        chk("rst_tick", tick, 0);
        // First ticks after release: tick in cycle 4, (0,0) with frame_start one cycle later
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("tick_k%0d", k), tick, (k % 4 == 3) ? 1 : 0);
            chk($sformatf("fs_k%0d", k), fs, (k == 4) ? 1 : 0);
            if (k == 4) begin
                chk("first_en", en, 1);
                chk("first_row", row, 0);
                chk("first_line", line, 0);
            end
            @(negedge clk);
        end
        // One full line
        big_reset();
        en_n = 0; hs_lo = 0; hs_first = -1; bad = 0; c0 = 0; c1 = 0;
        for (int t = 0; t <= 800; t++) begin
            wait_tick();
            if (t == 0) c0 = cyc;
            if (t == 800) c1 = cyc;
            @(negedge clk);
            if (t < 800) begin
                en_n += en;
                if (!hs) begin
                    hs_lo++;
                    if (hs_first < 0) hs_first = t;
                end
                if (row != ((t < 640) ? t : 0) || line != 0 || vs != 1) bad++;
            end
            if (t == 0) begin
                chk("line_fs0", fs, 1);
                @(negedge clk);
                chk("fs_one_cycle", fs, 0);
                chk("en_hold", en, 1);
            end
        end
        chk("line_en_ticks", en_n, 640);
        chk("line_hs_low", hs_lo, 96);
        chk("line_hs_first", hs_first, 656);
        chk("line_row_map", bad, 0);
        chk("line_period", c1 - c0, 3200);
        chk("line1_line", line, 1);
        chk("line1_row", row, 0);
        chk("line1_en", en, 1);
        chk("line1_fs", fs, 0);
        // Reset taken mid-line at h=700
        big_reset();
        for (int t = 0; t <= 700; t++) begin
            wait_tick();
            if (t < 700) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_en", en, 0);
        chk("mid_rst_hs", hs, 1);
        chk("mid_rst_row", row, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rel_tick", tick, 1);
        chk("mid_rel_fs_early", fs, 0);
        @(negedge clk);
        chk("mid_rel_fs", fs, 1);
        chk("mid_rel_en", en, 1);
        chk("mid_rel_row", row, 0);
        chk("mid_rel_line", line, 0);
        // Small CLK_DIV=1 DUT: sample k shows pixel index k (h = k%16, v = (k/16)%8)
        s_rst_n = 1'b1;
        b_row = 0; b_line = 0; b_en = 0; b_hs = 0; b_vs = 0; b_fs = 0; b_tick = 0;
        fs_n = 0; fs_last = 0; fs_gap = 0; vs_lo = 0; s_en_n = 0;
        for (int k = 0; k < 348; k++) begin
            @(negedge clk);
            h = k % 16;
            v = (k / 16) % 8;
            if (s_tick != 1) b_tick++;
            if (s_row != ((h < 8) ? h : 0)) b_row++;
            if (s_line != ((v < 4) ? v : 0)) b_line++;
            if (s_en != ((h < 8 && v < 4) ? 1 : 0)) b_en++;
            if (s_hs != ((h >= 10 && h < 13) ? 0 : 1)) b_hs++;
            if (s_vs != ((v >= 5 && v < 7) ? 0 : 1)) b_vs++;
            if (s_fs != ((h == 0 && v == 0) ? 1 : 0)) b_fs++;
            if (s_fs) begin
                if (fs_n == 1) fs_gap = k - fs_last;
                fs_last = k;
                fs_n++;
            end
            if (k < 128) begin
                if (!s_vs) vs_lo++;
                if (s_en) s_en_n++;
            end
        end
        chk("s_tick_every", b_tick, 0);
        chk("s_row_map", b_row, 0);
        chk("s_line_map", b_line, 0);
        chk("s_en_map", b_en, 0);
        chk("s_hs_map", b_hs, 0);
        chk("s_vs_map", b_vs, 0);
        chk("s_fs_map", b_fs, 0);
        chk("s_fs_count", fs_n, 3);
        chk("s_fs_period", fs_gap, 128);
        chk("s_vs_low_cycles", vs_lo, 32);
        chk("s_en_cycles", s_en_n, 32);
        chk("s_pre_rst_hs", s_hs, 0);
        chk("s_pre_rst_vs", s_vs, 0);
`ifdef VGA_FRAME_COUNTER_EN
        chk("s_fc_frames", s_fc, 3);
`endif
        // Small DUT reset mid-frame at h=11, v=5
        s_rst_n = 1'b0;
        @(negedge clk);
        chk("s_rst_hs", s_hs, 1);
        chk("s_rst_vs", s_vs, 1);
        chk("s_rst_en", s_en, 0);
        chk("s_rst_fs", s_fs, 0);
`ifdef VGA_FRAME_COUNTER_EN
        chk("s_rst_fc", s_fc, 0);
`endif
        s_rst_n = 1'b1;
        @(negedge clk);
        chk("s_rel_fs", s_fs, 1);
        chk("s_rel_en", s_en, 1);
        chk("s_rel_row", s_row, 0);
        chk("s_rel_line", s_line, 0);
`ifdef VGA_FRAME_COUNTER_EN
        chk("s_rel_fc", s_fc, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
